// File: rtl/cpu_mem_access_if.sv
// Data-bus interface between the MEM stage and the data memory / bus slave.
// Request side (driven by the master): bus_req, bus_we, bus_addr, bus_wdata, bus_be.
// Response side (driven by the slave): bus_ack, bus_rdata, bus_err.
// bus_rdata and bus_err are only meaningful in the bus_ack cycle.
// bus_ack is only sampled while bus_req is high.
interface cpu_mem_access_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [3:0]        bus_be;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata, bus_err
  );
endinterface

// File: rtl/cpu_mem_access.sv
// Memory-access (MEM) stage of the TrivialMIPS pipeline.
// Runs LW/SW over a req/ack data bus. It detects misaligned addresses and bus
// errors, and merges them with the exception record coming from EX.
// Ports:
//   clk, rst          pipeline clock, synchronous active-high reset
//   valid_in          EX/MEM register holds a live instruction
//   flush             commit logic squashes the instruction in this stage
//   hold              later stage stalled; a finished access keeps its result
//   req_*             memory request from EX (ce/we/addr/wdata/sel)
//   ret_in            EX result word
//   ex_occur/eret/code  upstream exception info
//   bus               data-bus master port (cpu_mem_access_if.master)
//   wb_data           write-back word
//   stall_req         freeze EX/MEM and earlier stages
//   exc_occur/eret/code, badvaddr  merged exception record for commit
module cpu_mem_access #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              flush,
  input  logic              hold,
  input  logic              req_ce,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_sel,
  input  logic [DATA_W-1:0] ret_in,
  input  logic              ex_occur,
  input  logic              ex_eret,
  input  logic [4:0]        ex_code,
  cpu_mem_access_if.master  bus,
  output logic [DATA_W-1:0] wb_data,
  output logic              stall_req,
  output logic              exc_occur,
  output logic              exc_eret,
  output logic [4:0]        exc_code,
  output logic [ADDR_W-1:0] badvaddr
);

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_DBE  = 5'h07;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic misaligned;
  logic go;

  assign misaligned = valid_in & req_ce & (req_addr[1:0] != 2'b00);
  assign go         = valid_in & req_ce & ~flush & ~ex_occur & (req_addr[1:0] == 2'b00);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. A transfer already on the bus is never abandoned:
  // a flush before the ack parks in ABORT until the slave completes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (go) state_nxt = REQ;
      REQ: begin
        if (bus.bus_ack) state_nxt = flush ? IDLE : DONE;
        else if (flush)  state_nxt = ABORT;
      end
      ABORT: if (bus.bus_ack) state_nxt = IDLE;
      DONE:  if (~hold | flush) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus request registers and captured response
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_be    <= 4'b0000;
      rdata_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= req_we;
            bus.bus_addr  <= req_addr;
            bus.bus_wdata <= req_wdata;
            bus.bus_be    <= req_sel;
          end
        end
        REQ: begin
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            // A flushed access completes on the bus but its data is dropped.
            if (~flush) begin
              rdata_q <= bus.bus_rdata;
              err_q   <= bus.bus_err;
            end
          end
        end
        ABORT: if (bus.bus_ack) bus.bus_req <= 1'b0;
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    stall_req = 1'b0;
    wb_data   = ret_in;
    exc_occur = 1'b0;
    exc_eret  = 1'b0;
    exc_code  = 5'h00;
    badvaddr  = '0;
    if (rst) begin
      wb_data = '0;
    end else begin
      case (state)
        IDLE:        stall_req = go;
        REQ, ABORT:  stall_req = 1'b1;
        default:     stall_req = 1'b0;
      endcase

      if (state == DONE && ~req_we) wb_data = rdata_q;

      // Exception merge; EX-stage exceptions win over anything found here.
      if (valid_in) begin
        if (ex_occur) begin
          exc_occur = 1'b1;
          exc_eret  = ex_eret;
          exc_code  = ex_code;
        end else if (misaligned) begin
          exc_occur = 1'b1;
          exc_code  = req_we ? EXC_ADES : EXC_ADEL;
          badvaddr  = req_addr;
        end else if (state == DONE && err_q) begin
          exc_occur = 1'b1;
          exc_code  = EXC_DBE;
          badvaddr  = req_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_access.sv
// Directed testbench for cpu_mem_access: drives EX-side inputs and acts as
// the bus slave by hand, checking outputs against hand-computed values.
module tb_cpu_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, flush, hold;
  logic        req_ce, req_we;
  logic [31:0] req_addr, req_wdata, ret_in;
  logic [3:0]  req_sel;
  logic        ex_occur, ex_eret;
  logic [4:0]  ex_code;
  logic [31:0] wb_data;
  logic        stall_req;
  logic        exc_occur, exc_eret;
  logic [4:0]  exc_code;
  logic [31:0] badvaddr;

  int n_chk = 0;
  int n_err = 0;

  cpu_mem_access_if bus_if ();

  cpu_mem_access dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .flush     (flush),
    .hold      (hold),
    .req_ce    (req_ce),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_sel   (req_sel),
    .ret_in    (ret_in),
    .ex_occur  (ex_occur),
    .ex_eret   (ex_eret),
    .ex_code   (ex_code),
    .bus       (bus_if),
    .wb_data   (wb_data),
    .stall_req (stall_req),
    .exc_occur (exc_occur),
    .exc_eret  (exc_eret),
    .exc_code  (exc_code),
    .badvaddr  (badvaddr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed away from it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    valid_in  = 1'b0; flush = 1'b0; hold = 1'b0;
    req_ce    = 1'b0; req_we = 1'b0;
    req_addr  = 32'h0; req_wdata = 32'h0; req_sel = 4'b0000;
    ret_in    = 32'h0;
    ex_occur  = 1'b0; ex_eret = 1'b0; ex_code = 5'h00;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0; bus_if.bus_err = 1'b0;
  endtask

  task automatic mem_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    valid_in = 1'b1; req_ce = 1'b1; req_we = we;
    req_addr = addr; req_wdata = wdata; req_sel = 4'b1111;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    // Live-looking inputs during reset must not leak to the outputs.
    valid_in = 1'b1; ex_occur = 1'b1; ex_code = 5'h0D; ret_in = 32'h5555_AAAA;
    cyc(); cyc();
    settle();
    check("rst bus_req",   {31'b0, bus_if.bus_req}, 32'h0);
    check("rst bus_we",    {31'b0, bus_if.bus_we},  32'h0);
    check("rst bus_addr",  bus_if.bus_addr,         32'h0);
    check("rst bus_wdata", bus_if.bus_wdata,        32'h0);
    check("rst bus_be",    {28'b0, bus_if.bus_be},  32'h0);
    check("rst stall",     {31'b0, stall_req},      32'h0);
    check("rst wb_data",   wb_data,                 32'h0);
    check("rst exc_occur", {31'b0, exc_occur},      32'h0);
    check("rst exc_code",  {27'b0, exc_code},       32'h0);
    check("rst badvaddr",  badvaddr,                32'h0);
    idle_inputs();
    rst = 1'b0;
    cyc();

    // Non-memory instruction: one cycle, no stall, result passes through.
    valid_in = 1'b1; ret_in = 32'h0000_0042;
    settle();
    check("alu stall", {31'b0, stall_req}, 32'h0);
    check("alu wb",    wb_data,            32'h0000_0042);
    cyc();
    check("alu no req", {31'b0, bus_if.bus_req}, 32'h0);
    idle_inputs();

    // LW, zero wait states.
    mem_req(1'b0, 32'h8000_0010, 32'h0); ret_in = 32'h1111_1111;
    settle();
    check("lw c0 stall", {31'b0, stall_req},      32'h1);
    check("lw c0 req",   {31'b0, bus_if.bus_req}, 32'h0);
    cyc();
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF;
    settle();
    check("lw c1 req",   {31'b0, bus_if.bus_req}, 32'h1);
    check("lw c1 we",    {31'b0, bus_if.bus_we},  32'h0);
    check("lw c1 be",    {28'b0, bus_if.bus_be},  32'hF);
    check("lw c1 addr",  bus_if.bus_addr,         32'h8000_0010);
    check("lw c1 stall", {31'b0, stall_req},      32'h1);
    cyc();
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    settle();
    check("lw c2 stall", {31'b0, stall_req},      32'h0);
    check("lw c2 wb",    wb_data,                 32'hDEAD_BEEF);
    check("lw c2 req",   {31'b0, bus_if.bus_req}, 32'h0);
    check("lw c2 exc",   {31'b0, exc_occur},      32'h0);
    cyc();
    idle_inputs(); ret_in = 32'h2222_2222;
    settle();
    check("lw after wb", wb_data, 32'h2222_2222);

    // SW with three slave wait cycles.
    mem_req(1'b1, 32'h8000_0020, 32'h1234_5678); ret_in = 32'h0000_0007;
    settle();
    check("sw c0 stall", {31'b0, stall_req}, 32'h1);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      bus_if.bus_ack = (i == 4);
      settle();
      check($sformatf("sw c%0d req", i),   {31'b0, bus_if.bus_req}, 32'h1);
      check($sformatf("sw c%0d addr", i),  bus_if.bus_addr,         32'h8000_0020);
      check($sformatf("sw c%0d wdata", i), bus_if.bus_wdata,        32'h1234_5678);
      check($sformatf("sw c%0d we", i),    {31'b0, bus_if.bus_we},  32'h1);
      check($sformatf("sw c%0d stall", i), {31'b0, stall_req},      32'h1);
    end
    cyc();
    bus_if.bus_ack = 1'b0;
    settle();
    check("sw done stall", {31'b0, stall_req},      32'h0);
    check("sw done req",   {31'b0, bus_if.bus_req}, 32'h0);
    check("sw done exc",   {31'b0, exc_occur},      32'h0);
    check("sw done wb",    wb_data,                 32'h0000_0007);
    cyc();
    idle_inputs();

    // Misaligned load, then the same address as a store.
    mem_req(1'b0, 32'h8000_0013, 32'h0);
    settle();
    check("adel stall", {31'b0, stall_req}, 32'h0);
    check("adel occur", {31'b0, exc_occur}, 32'h1);
    check("adel code",  {27'b0, exc_code},  32'h04);
    check("adel bva",   badvaddr,           32'h8000_0013);
    cyc();
    check("adel no req", {31'b0, bus_if.bus_req}, 32'h0);
    req_we = 1'b1;
    settle();
    check("ades code", {27'b0, exc_code}, 32'h05);
    check("ades bva",  badvaddr,          32'h8000_0013);
    cyc();
    check("ades no req", {31'b0, bus_if.bus_req}, 32'h0);
    idle_inputs();

    // LW terminated with a bus error.
    mem_req(1'b0, 32'h8000_0040, 32'h0);
    cyc();
    bus_if.bus_ack = 1'b1; bus_if.bus_err = 1'b1; bus_if.bus_rdata = 32'h0BAD_0BAD;
    cyc();
    bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0;
    settle();
    check("dbe occur", {31'b0, exc_occur}, 32'h1);
    check("dbe code",  {27'b0, exc_code},  32'h07);
    check("dbe bva",   badvaddr,           32'h8000_0040);
    cyc();
    idle_inputs();

    // Upstream exception on a store: passes through, no bus access.
    mem_req(1'b1, 32'h8000_0030, 32'hFFFF_0000);
    ex_occur = 1'b1; ex_code = 5'h0D;
    settle();
    check("exin occur", {31'b0, exc_occur}, 32'h1);
    check("exin code",  {27'b0, exc_code},  32'h0D);
    check("exin stall", {31'b0, stall_req}, 32'h0);
    cyc();
    check("exin no req", {31'b0, bus_if.bus_req}, 32'h0);
    idle_inputs();

    // Flush in the first REQ cycle of a three-wait-state access.
    mem_req(1'b0, 32'h8000_0050, 32'h0);
    cyc();
    flush = 1'b1;
    settle();
    check("abt c1 req",   {31'b0, bus_if.bus_req}, 32'h1);
    check("abt c1 stall", {31'b0, stall_req},      32'h1);
    cyc();
    idle_inputs();
    for (int i = 2; i <= 4; i++) begin
      bus_if.bus_ack = (i == 4);
      settle();
      check($sformatf("abt c%0d req", i),   {31'b0, bus_if.bus_req}, 32'h1);
      check($sformatf("abt c%0d addr", i),  bus_if.bus_addr,         32'h8000_0050);
      check($sformatf("abt c%0d stall", i), {31'b0, stall_req},      32'h1);
      cyc();
    end
    bus_if.bus_ack = 1'b0;
    settle();
    check("abt end req",   {31'b0, bus_if.bus_req}, 32'h0);
    check("abt end stall", {31'b0, stall_req},      32'h0);
    check("abt end exc",   {31'b0, exc_occur},      32'h0);
    cyc();

    // hold keeps DONE and its load data for two extra cycles.
    mem_req(1'b0, 32'h8000_0060, 32'h0); hold = 1'b1; ret_in = 32'h3333_3333;
    cyc();
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hCAFE_F00D;
    cyc();
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) hold = 1'b0;
      settle();
      check($sformatf("hold d%0d wb", i),    wb_data,            32'hCAFE_F00D);
      check($sformatf("hold d%0d stall", i), {31'b0, stall_req}, 32'h0);
      cyc();
    end
    idle_inputs(); ret_in = 32'h4444_4444;
    settle();
    check("hold exit wb", wb_data, 32'h4444_4444);

    // Reset in the middle of a transfer drops the request.
    mem_req(1'b1, 32'h8000_0070, 32'h0000_00AA);
    cyc();
    idle_inputs();
    settle();
    check("mid req", {31'b0, bus_if.bus_req}, 32'h1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    settle();
    check("mid rst req",   {31'b0, bus_if.bus_req}, 32'h0);
    check("mid rst stall", {31'b0, stall_req},      32'h0);
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_mem_access.md
# cpu_mem_access

Memory-access stage of the TrivialMIPS pipeline, directly downstream of the EX stage via the EX/MEM pipeline register. It consumes the EX memory request (ce/we/addr/wdata/sel), the EX result word and the EX exception info. It executes LW/SW on a req/ack data bus and detects address-alignment and bus-error exceptions. It produces the write-back word, a pipeline stall request and the merged exception record for the commit logic.

## Interface
Parameters:
- ADDR_W, 32, data-bus address width
- DATA_W, 32, data-bus data width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; synchronous, active-high
- valid_in  in  1  EX/MEM register holds a live instruction
- flush  in  1  commit logic is squashing the instruction in this stage
- hold  in  1  later stage stalled; a finished access must keep its result
- req_ce, req_we  in  1 each  memory request enable / write (from EX)
- req_addr  in  32  effective address
- req_wdata  in  32  store data
- req_sel  in  4  byte lanes (1111 for LW/SW, 0000 otherwise)
- ret_in  in  32  EX result word
- ex_occur, ex_eret  in  1 each; ex_code  in  5  upstream exception info
- bus_req  out  1  data-bus request
- bus_we  out  1  data-bus write
- bus_addr  out  32  data-bus address
- bus_wdata  out  32  data-bus write data
- bus_be  out  4  data-bus byte enables
- bus_ack  in  1  transfer complete; sampled only while bus_req=1
- bus_rdata  in  32  read data, valid in the bus_ack cycle
- bus_err  in  1  bus error, valid in the bus_ack cycle
- wb_data  out  32  write-back word
- stall_req  out  1  freeze EX/MEM and earlier stages
- exc_occur, exc_eret  out  1 each; exc_code  out  5  merged exception
- badvaddr  out  32  faulting address for CP0 BadVAddr

## Operation
- States: IDLE, REQ, DONE, ABORT.
- Launch condition, evaluated in IDLE: `go` = valid_in & req_ce & ~flush & ~ex_occur & (req_addr[1:0]==0).
- IDLE:
  - go → REQ; at the same edge, register bus_req=1, bus_we=req_we, bus_addr=req_addr, bus_wdata=req_wdata, bus_be=req_sel.
  - otherwise stay in IDLE.
- REQ: bus outputs are held stable until bus_ack=1.
  - ack with flush=0: latch bus_rdata into rdata_q and bus_err into err_q; drop bus_req; → DONE.
  - ack with flush=1: drop bus_req; discard data; → IDLE.
  - flush without ack → ABORT.
- ABORT: keep bus_req and bus outputs stable until bus_ack; then drop bus_req → IDLE. The transfer is never abandoned mid-bus.
- DONE:
  - ~hold or flush → IDLE.
  - otherwise stay in DONE and hold rdata_q.
- stall_req (combinational):
  - `go` in IDLE;
  - REQ or ABORT;
  - never in DONE.
- wb_data:
  - DONE with load (~req_we): rdata_q;
  - all other cases: ret_in.
- Exceptions, in priority order:
  1. ex_occur: pass ex_occur/ex_code/ex_eret through; no bus access.
  2. Misaligned access (valid_in & req_ce & addr[1:0]≠0): exc_occur=1, code 0x04 (AdEL) for a load or 0x05 (AdES) for a store; badvaddr=req_addr; no bus access; stall_req=0.
  3. DONE with err_q=1: exc_occur=1, code 0x07 (DBE), badvaddr=req_addr.
  4. Otherwise exc_occur=0, exc_code=0, exc_eret=0.
- While valid_in=0, exception outputs are forced to 0.
- Only the 32-bit LW/SW encodings are handled; sel is forwarded unchanged.

## Timing
- Reset (rst=1 at an edge): state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, rdata_q=0, err_q=0. Combinational outputs while rst=1: stall_req=0, wb_data=0, exc_*=0, badvaddr=0.
- rst mid-transaction returns to IDLE immediately and drops bus_req; the bus slave must tolerate this.
- Zero-wait-state access, cycles from the instruction entering MEM:
  - c0: IDLE, stall_req=1.
  - c1: REQ, bus_req=1, ack=1.
  - c2: DONE, stall_req=0, wb_data valid.
- Each slave wait cycle adds one cycle.
- A non-memory instruction spends one cycle in the stage with no stall.
- The next instruction is sampled in IDLE the cycle after DONE exits, so back-to-back accesses never merge.

## Test plan
- LW, addr 0x8000_0010, ack one cycle after req with rdata 0xDEAD_BEEF → stall_req 1,1,0; wb_data=0xDEAD_BEEF in DONE; bus_we=0; bus_be=1111.
- SW, addr 0x8000_0020, wdata 0x1234_5678, ack after 3 wait cycles → bus_req held 4 cycles with addr/wdata stable; bus_we=1; stall_req high for 5 cycles; exc_occur=0.
- LW, addr 0x8000_0013 → no bus_req; exc_occur=1; exc_code=0x04; badvaddr=0x8000_0013; stall_req=0. The same address as SW → code 0x05.
- LW with ack+bus_err=1 → DONE shows exc_code=0x07, badvaddr=req addr.
- ex_occur=1 with ex_code=0x0D on an SW → no bus_req; exc_code=0x0D passed through.
- flush in REQ cycle 1 of 3 wait cycles → ABORT; bus_req held until ack; stall_req=1 throughout; then IDLE with no exception. Separately, hold=1 in DONE for 2 cycles → wb_data stable at rdata_q.
